alu_ctrl: RTL and testbench

Command sequencer that drives the datapath ALU's operand/select interface and consumes its result and flags. Accepts operation commands over a valid/ready channel and holds an accumulator as bus_a. Applies the selected ALU operation 1..2^CNT_WIDTH times, one per cycle, and returns the result and flags over a valid/ready response channel. Sits between the instruction front-end and the combinational ALU.

---
 rtl/alu_ctrl_pkg.sv | 8 +
 rtl/alu_ctrl.sv | 78 +++++++
 tb/tb_alu_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode/state enums and default widths for the ALU command sequencer
package alu_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_WIDTH = 3;
  localparam int DEF_CNT_WIDTH = 4;
  typedef enum logic [2:0] {OP_LOAD = 3'b000, OP_ADD, OP_SUB, OP_MUL, OP_HALF} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: repeats an ALU op on an accumulator and returns the result; ALU_CTRL_ZERO_EARLY_EN stops a repeat as soon as the result reaches zero
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ALU_sel_WIDTH = DEF_SEL_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ALU_sel_WIDTH-1:0] cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [CNT_WIDTH-1:0]     cmd_rep,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_negative,
  output logic [WIDTH-1:0]         bus_a,
  output logic [WIDTH-1:0]         bus_b,
  output logic [ALU_sel_WIDTH-1:0] alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     zero,
  input  logic                     negative
);
  state_e state, state_nx;
  logic [WIDTH-1:0] acc, data_reg;
  logic [ALU_sel_WIDTH-1:0] op_reg;
  logic [CNT_WIDTH-1:0] cnt;
  logic zero_reg, neg_reg, done;
`ifdef ALU_CTRL_ZERO_EARLY_EN
  assign done = (cnt == '0) || zero;
`else
  assign done = (cnt == '0);
`endif
  // next state and handshake/ALU-drive outputs
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (cmd_valid ? EXEC : IDLE) :
               (state == EXEC) ? (done ? RESP : EXEC) :
               (rsp_ready ? IDLE : RESP);
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    alu_sel = (state == EXEC) ? op_reg : ALU_sel_WIDTH'(OP_LOAD);
    bus_a = acc;
    bus_b = data_reg;
    rsp_data = acc;
    rsp_zero = zero_reg;
    rsp_negative = neg_reg;
  end
  // state register, command latch, iteration counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      data_reg <= '0;
      op_reg <= '0;
      cnt <= '0;
      zero_reg <= 1'b0;
      neg_reg <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        op_reg <= cmd_op;
        data_reg <= cmd_data;
        cnt <= cmd_rep;
      end
      if (state == EXEC) begin
        acc <= alu_out;
        zero_reg <= zero;
        neg_reg <= negative;
        if (!done) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: table vectors, corner sequences and random commands against a behavioural accumulator model
module tb_alu_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [2:0] cmd_op = 0, alu_sel;
  logic [7:0] cmd_data = 0, rsp_data, bus_a, bus_b, alu_out;
  logic [3:0] cmd_rep = 0;
  logic rsp_zero, rsp_negative, zero, negative;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] macc;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic [3:0] rep;
    logic [7:0] ed;
    logic ez, en;
    int lat;
  } vec_t;
  vec_t tv[13];

  alu_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .bus_a(bus_a),
    .bus_b(bus_b), .alu_sel(alu_sel), .alu_out(alu_out), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int x, y, r;
    x = int'($signed(a));
    y = int'($signed(b));
    r = (op == 1) ? x + y : (op == 2) ? x - y : (op == 3) ? x * y : (op == 4) ? x / 2 : y;
    return r[7:0];
  endfunction

  always_comb begin
    alu_out = ref_op(alu_sel, bus_a, bus_b);
    zero = (alu_out == 8'd0);
    negative = alu_out[7];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [7:0] d, input logic [3:0] rep,
                       output logic [7:0] ed, output logic ez, output logic en, output int lat);
    logic [7:0] a;
    a = macc;
    lat = 0;
    for (int i = 0; i <= int'(rep); i++) begin
      a = ref_op(op, a, d);
      lat++;
`ifdef ALU_CTRL_ZERO_EARLY_EN
      if (a == 8'd0) break;
`endif
    end
    macc = a;
    ed = a;
    ez = (a == 8'd0);
    en = a[7];
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [3:0] rep);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", 32'(w < 50), 1);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    cmd_rep = rep;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    cmd_op = 3'($urandom);
    cmd_data = 8'($urandom);
    cmd_rep = 4'($urandom);
  endtask

  task automatic get_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_rsp(input string name, input int hold);
    logic [7:0] d0;
    d0 = rsp_data;
    rsp_ready = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s hold_data", name), rsp_data, d0);
      chk($sformatf("%s hold_ready", name), cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk($sformatf("%s back_idle", name), {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic do_cmd(input string name, input logic [2:0] op, input logic [7:0] d, input logic [3:0] rep,
                        input logic [7:0] ed, input logic ez, input logic en, input int elat, input int hold);
    int lat;
    issue(op, d, rep);
    get_rsp(lat);
    chk($sformatf("%s latency", name), lat, elat);
    chk($sformatf("%s data", name), rsp_data, ed);
    chk($sformatf("%s flags", name), {rsp_zero, rsp_negative}, {ez, en});
    release_rsp(name, hold);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ed;
    logic ez, en;
    int lat, seen;
    tv[0]  = '{3'd0, 8'd5,   4'd0, 8'd5,   1'b0, 1'b0, 1};
    tv[1]  = '{3'd2, 8'd7,   4'd0, 8'hFE,  1'b0, 1'b1, 1};
    tv[2]  = '{3'd0, 8'd100, 4'd0, 8'd100, 1'b0, 1'b0, 1};
    tv[3]  = '{3'd4, 8'd0,   4'd3, 8'd6,   1'b0, 1'b0, 4};
    tv[4]  = '{3'd0, 8'hFD,  4'd0, 8'hFD,  1'b0, 1'b1, 1};
    tv[5]  = '{3'd4, 8'd0,   4'd0, 8'hFF,  1'b0, 1'b1, 1};
    tv[6]  = '{3'd0, 8'd127, 4'd0, 8'h7F,  1'b0, 1'b0, 1};
    tv[7]  = '{3'd1, 8'd1,   4'd0, 8'h80,  1'b0, 1'b1, 1};
    tv[8]  = '{3'd0, 8'd16,  4'd0, 8'd16,  1'b0, 1'b0, 1};
    tv[9]  = '{3'd3, 8'd16,  4'd0, 8'd0,   1'b1, 1'b0, 1};
    tv[10] = '{3'd0, 8'd3,   4'd0, 8'd3,   1'b0, 1'b0, 1};
`ifdef ALU_CTRL_ZERO_EARLY_EN
    tv[11] = '{3'd4, 8'd0,   4'd7, 8'd0,   1'b1, 1'b0, 2};
`else
    tv[11] = '{3'd4, 8'd0,   4'd7, 8'd0,   1'b1, 1'b0, 8};
`endif
    tv[12] = '{3'd5, 8'd9,   4'd2, 8'd9,   1'b0, 1'b0, 3};
`ifdef ALU_CTRL_ZERO_EARLY_EN
    tv[12].lat = 3;
`endif
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset outputs", {cmd_ready, rsp_valid, alu_sel}, {1'b1, 1'b0, 3'd0});
    chk("reset buses", {bus_a, bus_b}, 16'd0);
    for (int i = 0; i < 13; i++)
      do_cmd($sformatf("vec%0d", i), tv[i].op, tv[i].d, tv[i].rep, tv[i].ed, tv[i].ez, tv[i].en, tv[i].lat, i % 3);
    macc = 8'd9;
    issue(3'd0, 8'd42, 4'd0);
    get_rsp(lat);
    chk("bp latency", lat, 1);
    cmd_valid = 1;
    cmd_op = 3'd1;
    cmd_data = 8'd1;
    cmd_rep = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp stall%0d", i), {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, 8'd42});
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("bp idle", {rsp_valid, cmd_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    get_rsp(lat);
    chk("bp next latency", lat, 1);
    chk("bp next data", rsp_data, 8'd43);
    release_rsp("bp next", 0);
    issue(3'd1, 8'd1, 4'd7);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midreset state", {rsp_valid, cmd_ready, alu_sel}, {1'b0, 1'b1, 3'd0});
    chk("midreset buses", {bus_a, bus_b}, 16'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midreset no rsp", seen, 0);
    do_cmd("post_rst load0", 3'd0, 8'd0, 4'd0, 8'd0, 1'b1, 1'b0, 1, 0);
    do_cmd("post_rst add4", 3'd1, 8'd4, 4'd0, 8'd4, 1'b0, 1'b0, 1, 1);
    macc = 8'd4;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] d;
      logic [3:0] rep;
      op = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      rep = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      model(op, d, rep, ed, ez, en, lat);
      do_cmd($sformatf("rnd%0d", i), op, d, rep, ed, ez, en, lat, $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
